mem_stage: RTL
==============

# mem_stage

Pipeline MEM stage of the MIPS core: accepts one EX-stage operation at a time and performs the data-memory access through a req/ack handshake. It aligns, sign- or zero-extends load data and registers the result into the MEM/WB boundary, driving `MemtoReg`, `readdata` and `aluRsltt` directly into the write-back mux. Upstream is stalled while a memory transaction is outstanding.

## Interface
Parameters:
- `DATA_W`, 32: datapath width; only 32 is supported.
- `ADDR_W`, 32: data-memory byte-address width.

Ports (one clock `clk`; reset `rst` is synchronous and active-high):
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  EX stage presents an operation
- `in_ready`  out  1  stage can accept; equals `state==IDLE`
- `MemRead`  in  1  load operation
- `MemWrite`  in  1  store operation; never set together with `MemRead`
- `MemtoReg_in`  in  1  passed to WB
- `RegWrite_in`  in  1  passed to WB
- `wreg_in`  in  5  destination register
- `size`  in  2  access size: 00 byte, 01 half, 10 word
- `sign_ext`  in  1  load sign-extension (lb/lh)
- `alu_result`  in  32  effective address, or ALU result
- `store_data`  in  32  rt value for stores
- `dmem_req`  out  1  memory request, held until ack
- `dmem_we`  out  1  write request
- `dmem_addr`  out  ADDR_W  word-aligned address (`[1:0]`=0)
- `dmem_wdata`  out  32  lane-replicated store data
- `dmem_be`  out  4  byte enables, little-endian lanes
- `dmem_ack`  in  1  one-cycle completion strobe
- `dmem_rdata`  in  32  read word, valid with `dmem_ack`
- `wb_valid`  out  1  one-cycle pulse: WB outputs are new
- `MemtoReg`, `RegWrite`  out  1 each  registered controls
- `wreg`  out  5  registered destination
- `readdata`  out  32  aligned/extended load data
- `aluRsltt`  out  32  registered `alu_result`
- `align_err`  out  1  one-cycle pulse with `wb_valid` on a misaligned access

## Operation
- FSM states: IDLE and WAIT_ACK.
- IDLE, accept (`in_valid`):
  - Non-memory op: the WB registers load on this edge with `wb_valid`=1. State stays IDLE.
  - Aligned memory op: latch the op and go to WAIT_ACK. `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_wdata` and `dmem_be` are registered and asserted from the next cycle.
  - Misaligned op (half with `addr[0]`, or word with `addr[1:0]`≠0): no request is issued. WB loads with `RegWrite`=0, `align_err`=1 and `wb_valid`=1. State stays IDLE.
- WAIT_ACK: the request is held stable until `dmem_ack`. On the ack edge:
  - `dmem_req` drops.
  - The WB registers load. For loads, `readdata` = extracted lane(s) from `dmem_rdata`, extended per `sign_ext`.
  - `wb_valid`=1 and the FSM returns to IDLE.
  - The next op is accepted the following cycle; there is no back-to-back accept on the ack cycle.
- Byte enables and store data:
  - byte: `be`=1<<addr[1:0], wdata = {4{b}}.
  - half: `be`=0011 or 1100, wdata = {2{h}}.
  - word: `be`=1111.
- Stores: `readdata` is unchanged. `RegWrite` passes through as given (0 for sw).
- When `wb_valid`=0, WB outputs hold their last values; WB must not commit them.
- `dmem_ack` while IDLE is ignored.

## Timing
- Reset: state IDLE. All outputs are 0, including `dmem_*`, `wb_valid`, `align_err`, `readdata`, `aluRsltt` and `wreg`. `in_ready`=1 from the first cycle after reset.
- Reset during WAIT_ACK: `dmem_req`=0 next cycle and the transaction is abandoned. A late ack is ignored.
- Latency:
  - Non-memory op: 1 cycle.
  - Memory op: 1 + N cycles, where N is the cycle count from the first `dmem_req` to `dmem_ack` inclusive; N≥1.
  - Zero-wait memory (ack on the first req cycle): 2 cycles total.
- Throughput: 1 op/cycle for non-memory ops. Memory ops occupy the stage for N+1 cycles.

## Structure
- Package `mips_mem_pkg`:
  - size encodings `SZ_BYTE`/`SZ_HALF`/`SZ_WORD`
  - FSM state enum
  - function computing `be` from size and address
- Sub-module `load_align`: purely combinational. Inputs are the rdata word, `addr[1:0]`, `size` and `sign_ext`; output is the 32-bit result.
- The top level holds the FSM, the latched-op registers and the WB registers.

## Test plan
- Non-memory op, `alu_result`=0x0000_1234 → next cycle `wb_valid`=1, `aluRsltt`=0x1234, `MemtoReg`=0, no `dmem_req`.
- lb at address 0x103 with `sign_ext`=1, ack after 3 req cycles with rdata=0x80FF_0000 → `dmem_addr`=0x100, `be`=1000, `readdata`=0xFFFF_FF80, total latency 4 cycles, `in_ready`=0 throughout.
- lhu at 0x202, rdata=0x8001_0000, zero-wait ack → `readdata`=0x0000_8001, latency 2 cycles.
- sb at 0x301, `store_data`=0xAB → `be`=0010, `wdata`=0xABAB_ABAB, `dmem_we`=1 held until ack.
- lw at 0x402 → no request; `align_err`=1, `wb_valid`=1 and `RegWrite`=0 in the same cycle.
- `rst` asserted in WAIT_ACK, then a late `dmem_ack` → `dmem_req`=0 the cycle after reset; the ack produces no `wb_valid`; all outputs are 0.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared definitions for the MEM pipeline stage.
//   - access-size encodings (SZ_BYTE / SZ_HALF / SZ_WORD)
//   - MEM-stage FSM state type
//   - calc_be(): byte-enable pattern from access size and address low bits
package mips_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } mem_state_e;

    // Little-endian lanes: lane n covers bits [8n+7:8n]. Encoding 2'b11 is treated as a word.
    function automatic logic [3:0] calc_be(input logic [1:0] sz, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (sz)
            SZ_BYTE: be = 4'b0001 << addr_lo;
            SZ_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/load_align.sv
// load_align: combinational load-data extraction for the MEM stage.
// Ports:
//   i_rdata    [31:0]  word returned by data memory
//   i_addr_lo  [1:0]   byte offset of the access
//   i_size     [1:0]   access size (SZ_BYTE / SZ_HALF / SZ_WORD)
//   i_sign_ext         sign-extend byte/half results (lb/lh)
//   o_result   [31:0]  lane-selected, extended load value
module load_align
    import mips_mem_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_size,
    input  logic        i_sign_ext,
    output logic [31:0] o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_size)
            SZ_BYTE: o_result = {{24{i_sign_ext & w_byte[7]}}, w_byte};
            SZ_HALF: o_result = {{16{i_sign_ext & w_half[15]}}, w_half};
            default: o_result = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MIPS pipeline MEM stage.
// Accepts one EX operation at a time, performs the data-memory access over a req/ack
// handshake, aligns/extends load data and registers the MEM/WB boundary.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid / in_ready           EX-side handshake; in_ready is high only in IDLE
//   MemRead, MemWrite             load / store (mutually exclusive)
//   MemtoReg_in, RegWrite_in      WB controls carried through
//   wreg_in, size, sign_ext       destination, access size, load extension
//   alu_result, store_data        effective address / ALU result, store value
//   dmem_req/we/addr/wdata/be     registered memory request, held until dmem_ack
//   dmem_ack, dmem_rdata          one-cycle completion strobe and read word
//   wb_valid                      one-cycle pulse when WB outputs are new
//   MemtoReg, RegWrite, wreg      registered WB controls
//   readdata, aluRsltt            registered load data and ALU result
//   align_err                     pulses with wb_valid on a misaligned access
module mem_stage
    import mips_mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              MemtoReg_in,
    input  logic              RegWrite_in,
    input  logic [4:0]        wreg_in,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] store_data,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic [3:0]        dmem_be,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              wb_valid,
    output logic              MemtoReg,
    output logic              RegWrite,
    output logic [4:0]        wreg,
    output logic [DATA_W-1:0] readdata,
    output logic [DATA_W-1:0] aluRsltt,
    output logic              align_err
);

    mem_state_e r_state;
    mem_state_e w_state_d;

    // Request registers
    logic              r_req;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [3:0]        r_be;

    // Operation latched while the transaction is outstanding
    logic              r_op_read;
    logic              r_op_m2r;
    logic              r_op_rw;
    logic [4:0]        r_op_wreg;
    logic [1:0]        r_op_size;
    logic              r_op_sext;
    logic [DATA_W-1:0] r_op_alu;

    // MEM/WB boundary
    logic              r_wb_valid;
    logic              r_m2r;
    logic              r_rw;
    logic [4:0]        r_wreg;
    logic [DATA_W-1:0] r_readdata;
    logic [DATA_W-1:0] r_alu;
    logic              r_align_err;

    logic              w_accept;
    logic              w_is_mem;
    logic              w_misalign;
    logic              w_start_mem;
    logic              w_done;
    logic [DATA_W-1:0] w_wdata;
    logic [31:0]       w_load_data;

    assign w_accept    = (r_state == IDLE) && in_valid;
    assign w_is_mem    = MemRead || MemWrite;
    // Size 2'b11 is handled as a word, consistent with calc_be().
    assign w_misalign  = w_is_mem &&
                         (((size == SZ_HALF) && alu_result[0]) ||
                          ((size != SZ_BYTE) && (size != SZ_HALF) && (alu_result[1:0] != 2'b00)));
    assign w_start_mem = w_accept && w_is_mem && !w_misalign;
    assign w_done      = (r_state == WAIT_ACK) && dmem_ack;

    always_comb begin
        case (size)
            SZ_BYTE: w_wdata = {4{store_data[7:0]}};
            SZ_HALF: w_wdata = {2{store_data[15:0]}};
            default: w_wdata = store_data;
        endcase
    end

    load_align u_load_align (
        .i_rdata    (dmem_rdata),
        .i_addr_lo  (r_op_alu[1:0]),
        .i_size     (r_op_size),
        .i_sign_ext (r_op_sext),
        .o_result   (w_load_data)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_d;
    end

    // FSM next state
    always_comb begin
        w_state_d = r_state;
        case (r_state)
            IDLE:     if (w_start_mem) w_state_d = WAIT_ACK;
            WAIT_ACK: if (dmem_ack)    w_state_d = IDLE;
            default:  w_state_d = IDLE;
        endcase
    end

    // Request and latched-operation registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_be      <= 4'b0000;
            r_op_read <= 1'b0;
            r_op_m2r  <= 1'b0;
            r_op_rw   <= 1'b0;
            r_op_wreg <= 5'd0;
            r_op_size <= 2'b00;
            r_op_sext <= 1'b0;
            r_op_alu  <= '0;
        end else if (w_start_mem) begin
            r_req     <= 1'b1;
            r_we      <= MemWrite;
            r_addr    <= {alu_result[ADDR_W-1:2], 2'b00};
            r_wdata   <= w_wdata;
            r_be      <= calc_be(size, alu_result[1:0]);
            r_op_read <= MemRead;
            r_op_m2r  <= MemtoReg_in;
            r_op_rw   <= RegWrite_in;
            r_op_wreg <= wreg_in;
            r_op_size <= size;
            r_op_sext <= sign_ext;
            r_op_alu  <= alu_result;
        end else if (w_done) begin
            r_req <= 1'b0;
            r_we  <= 1'b0;
        end
    end

    // MEM/WB registers; wb_valid and align_err are single-cycle pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb_valid  <= 1'b0;
            r_m2r       <= 1'b0;
            r_rw        <= 1'b0;
            r_wreg      <= 5'd0;
            r_readdata  <= '0;
            r_alu       <= '0;
            r_align_err <= 1'b0;
        end else begin
            r_wb_valid  <= 1'b0;
            r_align_err <= 1'b0;
            if (w_done) begin
                r_wb_valid <= 1'b1;
                r_m2r      <= r_op_m2r;
                r_rw       <= r_op_rw;
                r_wreg     <= r_op_wreg;
                r_alu      <= r_op_alu;
                if (r_op_read) r_readdata <= w_load_data;
            end else if (w_accept && !w_start_mem) begin
                // Non-memory op or misaligned access: completes without a request.
                r_wb_valid  <= 1'b1;
                r_m2r       <= MemtoReg_in;
                r_rw        <= RegWrite_in && !w_misalign;
                r_wreg      <= wreg_in;
                r_alu       <= alu_result;
                r_align_err <= w_misalign;
            end
        end
    end

    assign in_ready   = (r_state == IDLE);
    assign dmem_req   = r_req;
    assign dmem_we    = r_we;
    assign dmem_addr  = r_addr;
    assign dmem_wdata = r_wdata;
    assign dmem_be    = r_be;
    assign wb_valid   = r_wb_valid;
    assign MemtoReg   = r_m2r;
    assign RegWrite   = r_rw;
    assign wreg       = r_wreg;
    assign readdata   = r_readdata;
    assign aluRsltt   = r_alu;
    assign align_err  = r_align_err;

endmodule
